// File: rtl/ser2par_rx.sv
// Serial-to-parallel receiver: frames WORD_SIZE LSB-first bits after a frame_start marker
// and hands the completed word to a valid/ready output register.
module ser2par_rx #(
    parameter int WORD_SIZE = 4,
    parameter int CNT_W     = $clog2(WORD_SIZE + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ser_in,
    input  logic                 ser_valid,
    input  logic                 frame_start,
    output logic [WORD_SIZE-1:0] par_out,
    output logic                 par_valid,
    input  logic                 par_ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun_err
);

    localparam logic [0:0]       IDLE     = 1'b0;
    localparam logic [0:0]       SHIFT    = 1'b1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_SIZE - 1);

    // The lowest shift-register bit would be shifted out before it is ever used,
    // so only the upper WORD_SIZE-1 bits are kept.
    logic [0:0]           state_q, state_d;
    logic [WORD_SIZE-2:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WORD_SIZE-1:0] parOut_q, parOut_d;
    logic                 parValid_q, parValid_d;
    logic                 frameErr_q, frameErr_d;
    logic                 overrunErr_q, overrunErr_d;
    logic [WORD_SIZE-1:0] loadWord;
    logic                 complete;

    assign loadWord = {ser_in, sreg_q};

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        cnt_d      = cnt_q;
        frameErr_d = 1'b0;
        complete   = 1'b0;
        if (ser_valid) begin
            if (frame_start) begin
                state_d    = SHIFT;
                sreg_d     = loadWord[WORD_SIZE-1:1];
                cnt_d      = CNT_W'(1);
                frameErr_d = (state_q == SHIFT);
            end else if (state_q == SHIFT) begin
                sreg_d = loadWord[WORD_SIZE-1:1];
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = '0;
                end
            end
        end
    end

    // A completing word may replace a held one only if the consumer takes the old one this edge.
    always_comb begin
        parOut_d     = parOut_q;
        parValid_d   = parValid_q;
        overrunErr_d = overrunErr_q;
        if (complete) begin
            if (!parValid_q || par_ready) begin
                parOut_d   = loadWord;
                parValid_d = 1'b1;
            end else begin
                overrunErr_d = 1'b1;
            end
        end else if (parValid_q && par_ready) begin
            parValid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            sreg_q       <= '0;
            cnt_q        <= '0;
            parOut_q     <= '0;
            parValid_q   <= 1'b0;
            frameErr_q   <= 1'b0;
            overrunErr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            cnt_q        <= cnt_d;
            parOut_q     <= parOut_d;
            parValid_q   <= parValid_d;
            frameErr_q   <= frameErr_d;
            overrunErr_q <= overrunErr_d;
        end
    end

    assign par_out     = parOut_q;
    assign par_valid   = parValid_q;
    assign busy        = (state_q == SHIFT);
    assign frame_err   = frameErr_q;
    assign overrun_err = overrunErr_q;

endmodule

// File: tb/tb_ser2par_rx.sv
// Self-checking bench for ser2par_rx: directed frames, a vector table and randomized
// traffic compared against a bit-indexed behavioural model.
module tb_ser2par_rx;

    localparam int W = 4;

    logic         clock;
    logic         reset;
    logic         ser_in;
    logic         ser_valid;
    logic         frame_start;
    logic [W-1:0] par_out;
    logic         par_valid;
    logic         par_ready;
    logic         busy;
    logic         frame_err;
    logic         overrun_err;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model: the frame is collected by bit index, not by shifting.
    logic [W-1:0] mWord, mOut;
    int           mCount;
    logic         mBusy, mValid, mErr, mOverrun;

    typedef struct {
        logic [W-1:0] bits;
        int           gap;
        logic [W-1:0] expOut;
    } frameVec_t;

    frameVec_t vecs[6];

    ser2par_rx #(.WORD_SIZE(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .ser_in     (ser_in),
        .ser_valid  (ser_valid),
        .frame_start(frame_start),
        .par_out    (par_out),
        .par_valid  (par_valid),
        .par_ready  (par_ready),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun_err(overrun_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic modelStep(input logic rst, input logic sv, input logic fs,
                             input logic si, input logic rdy);
        logic done;
        done = 1'b0;
        mErr = 1'b0;
        if (rst) begin
            mWord = '0; mOut = '0; mCount = 0;
            mBusy = 1'b0; mValid = 1'b0; mOverrun = 1'b0;
            return;
        end
        if (sv && fs) begin
            mErr     = mBusy;
            mWord    = '0;
            mWord[0] = si;
            mCount   = 1;
            mBusy    = 1'b1;
        end else if (sv && mBusy) begin
            mWord[mCount] = si;
            mCount++;
            if (mCount == W) begin
                done  = 1'b1;
                mBusy = 1'b0;
            end
        end
        if (done) begin
            if (!mValid || rdy) begin
                mOut   = mWord;
                mValid = 1'b1;
            end else begin
                mOverrun = 1'b1;
            end
        end else if (mValid && rdy) begin
            mValid = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic sv, input logic fs,
                                 input logic si, input logic rdy);
        reset       = rst;
        ser_valid   = sv;
        frame_start = fs;
        ser_in      = si;
        par_ready   = rdy;
        modelStep(rst, sv, fs, si, rdy);
        @(posedge clock);
        #1;
        checkOutput("model_par_valid", 32'(par_valid), 32'(mValid));
        checkOutput("model_par_out", 32'(par_out), 32'(mOut));
        checkOutput("model_busy", 32'(busy), 32'(mBusy));
        checkOutput("model_frame_err", 32'(frame_err), 32'(mErr));
        checkOutput("model_overrun_err", 32'(overrun_err), 32'(mOverrun));
    endtask

    task automatic sendFrame(input logic [W-1:0] bits, input int gap, input logic rdy);
        for (int i = 0; i < W; i++) begin
            applyStimulus(1'b0, 1'b1, (i == 0), bits[i], rdy);
            if (i < W - 1)
                for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, rdy);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_par_out"}, 32'(par_out), 32'h0);
        checkOutput({tag, "_par_valid"}, 32'(par_valid), 32'h0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
        checkOutput({tag, "_frame_err"}, 32'(frame_err), 32'h0);
        checkOutput({tag, "_overrun_err"}, 32'(overrun_err), 32'h0);
    endtask

    initial begin
        logic [W-1:0] bits;
        logic         sv, fs, rdy, rst;

        vecs[0] = '{bits: 4'h3, gap: 0, expOut: 4'h3};
        vecs[1] = '{bits: 4'hF, gap: 1, expOut: 4'hF};
        vecs[2] = '{bits: 4'h0, gap: 2, expOut: 4'h0};
        vecs[3] = '{bits: 4'h9, gap: 0, expOut: 4'h9};
        vecs[4] = '{bits: 4'hC, gap: 3, expOut: 4'hC};
        vecs[5] = '{bits: 4'h8, gap: 0, expOut: 4'h8};

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkAllZero("reset");

        // Basic frame 1,0,1,1
        sendFrame(4'hD, 0, 1'b1);
        checkOutput("basic_par_out", 32'(par_out), 32'hD);
        checkOutput("basic_par_valid", 32'(par_valid), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("basic_consumed", 32'(par_valid), 32'h0);

        // Gapped frame: busy stays up across the gaps
        bits = 4'hD;
        for (int i = 0; i < W; i++) begin
            applyStimulus(1'b0, 1'b1, (i == 0), bits[i], 1'b1);
            if (i < W - 1) begin
                checkOutput("gap_busy_bit", 32'(busy), 32'h1);
                for (int g = 0; g < 3; g++) begin
                    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                    checkOutput("gap_busy_idle", 32'(busy), 32'h1);
                end
            end
        end
        checkOutput("gap_par_out", 32'(par_out), 32'hD);
        checkOutput("gap_par_valid", 32'(par_valid), 32'h1);
        checkOutput("gap_busy_done", 32'(busy), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        for (int v = 0; v < 6; v++) begin
            sendFrame(vecs[v].bits, vecs[v].gap, 1'b1);
            checkOutput("vec_par_out", 32'(par_out), 32'(vecs[v].expOut));
            checkOutput("vec_par_valid", 32'(par_valid), 32'h1);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            checkOutput("vec_consumed", 32'(par_valid), 32'h0);
        end

        // Back-pressure: second word is dropped
        sendFrame(4'hD, 0, 1'b0);
        sendFrame(4'h6, 0, 1'b0);
        checkOutput("ovr_par_out", 32'(par_out), 32'hD);
        checkOutput("ovr_par_valid", 32'(par_valid), 32'h1);
        checkOutput("ovr_overrun", 32'(overrun_err), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("ovr_consumed", 32'(par_valid), 32'h0);
        checkOutput("ovr_sticky", 32'(overrun_err), 32'h1);
        checkOutput("ovr_hold_out", 32'(par_out), 32'hD);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ovr_reset_clear", 32'(overrun_err), 32'h0);

        // Consume and complete on the same edge
        sendFrame(4'hA, 0, 1'b0);
        checkOutput("sim_first_out", 32'(par_out), 32'hA);
        bits = 4'h5;
        for (int i = 0; i < W; i++) applyStimulus(1'b0, 1'b1, (i == 0), bits[i], (i == W - 1));
        checkOutput("sim_par_out", 32'(par_out), 32'h5);
        checkOutput("sim_par_valid", 32'(par_valid), 32'h1);
        checkOutput("sim_overrun", 32'(overrun_err), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Resync after 1,1 with a new frame 0,0,1,0
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("resync_err_pulse", 32'(frame_err), 32'h1);
        checkOutput("resync_busy", 32'(busy), 32'h1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("resync_err_clear", 32'(frame_err), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("resync_par_out", 32'(par_out), 32'h4);
        checkOutput("resync_par_valid", 32'(par_valid), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset mid-frame, then a clean 0,1,1,1 frame
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        checkAllZero("midreset");
        sendFrame(4'hE, 0, 1'b1);
        checkOutput("midreset_par_out", 32'(par_out), 32'hE);
        checkOutput("midreset_par_valid", 32'(par_valid), 32'h1);

        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            sv  = ($urandom_range(0, 9) < 7);
            fs  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 1) == 1);
            applyStimulus(rst, sv, fs, 1'($urandom_range(0, 1)), rdy);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/ser2par_rx.md
Name: ser2par_rx

Overview:
Serial-to-parallel receiver for the LSB-first serial stream produced by the team's shift-register serializers. It frames WORD_SIZE bits starting at a frame_start marker and assembles them with a right-shifting register. The completed word goes into a separate output register with a valid/ready handshake, so the next frame can be received while the previous word waits for the consumer. It sits at the receive end of the on-chip serial link, in front of the parallel datapath.

Parameters:
WORD_SIZE, 4, bits per frame; legal values >= 2.
CNT_W, $clog2(WORD_SIZE+1), bit-counter width; derived, do not override.

Ports:
clock  input  1  single clock; all state changes on posedge.
reset  input  1  synchronous reset, active-high.
ser_in  input  1  serial data bit, LSB first.
ser_valid  input  1  ser_in is sampled on this edge only when ser_valid=1.
frame_start  input  1  qualified by ser_valid; marks the current bit as bit 0 of a new frame.
par_out  output  WORD_SIZE  assembled word, bit i = i-th received bit.
par_valid  output  1  par_out holds an unconsumed word.
par_ready  input  1  consumer accepts par_out when par_valid=1 and par_ready=1.
busy  output  1  high while in SHIFT.
frame_err  output  1  one-cycle pulse: frame_start arrived mid-frame.
overrun_err  output  1  sticky: a completed word was dropped; cleared only by reset.

Behaviour:
- Reset (reset=1 at a posedge) overrides everything:
  - state=IDLE; shift register, bit count and par_out all set to 0.
  - par_valid, busy, frame_err and overrun_err all set to 0.
  - This applies mid-frame too; a partial frame is discarded.
- Shift register rule: sreg <= {ser_in, sreg[WORD_SIZE-1:1]} on each accepted bit. After WORD_SIZE accepted bits, the first bit sits at sreg[0].
- States:
  - IDLE:
    - ser_valid=1 and frame_start=1: shift the bit in, cnt=1, go to SHIFT.
    - ser_valid=1 and frame_start=0: bit ignored.
  - SHIFT:
    - ser_valid=0: hold all state; gaps of any length are allowed.
    - ser_valid=1 and frame_start=0: shift, cnt+1.
    - When cnt reaches WORD_SIZE on this edge, the word is complete (see completion rules); go to IDLE.
    - ser_valid=1 and frame_start=1 (resync): discard the partial frame, treat this bit as bit 0 (cnt=1), stay in SHIFT, and pulse frame_err for one cycle.
- Completion rules (evaluated on the edge that accepts the last bit):
  - Load value is the fully shifted word {ser_in, sreg[WORD_SIZE-1:1]}.
  - par_valid=0: par_out <= load value, par_valid <= 1.
  - par_valid=1 and par_ready=1: the old word is consumed and the new word loaded the same edge; par_valid stays 1.
  - par_valid=1 and par_ready=0: the new word is dropped, par_out is unchanged, overrun_err <= 1.
- Latency: par_valid and par_out update on the same posedge that samples the last bit, so they are visible in the next cycle. Minimum frame-to-frame spacing is WORD_SIZE accepted bits, with no dead cycle.
- Handshake:
  - A word is consumed on a posedge with par_valid=1 and par_ready=1, with no completion on that edge; par_valid then drops to 0.
  - par_out holds its value after consumption. It is only meaningful while par_valid=1.
  - par_ready is ignored while par_valid=0.
- busy equals (state==SHIFT).
- frame_err is high for exactly one cycle per resync event.
- The receiver never stalls the serial side; there is no ser_ready, and loss is reported only via overrun_err.

Test Plan:
- Basic frame (WORD_SIZE=4, par_ready=1): bits 1,0,1,1 with frame_start on the first -> par_out=4'hD and par_valid=1 the cycle after the 4th bit; par_valid=0 one cycle later.
- Gapped input: same frame with ser_valid=0 for 3 cycles between each bit -> identical result (4'hD); busy=1 from the first bit until completion.
- Back-pressure and overrun: par_ready=0, send 4'hD then 4'h6 -> par_out stays 4'hD and overrun_err=1. Raise par_ready -> 4'hD consumed; overrun_err remains 1.
- Simultaneous consume and complete: par_valid=1 with 4'hA, then par_ready=1 on the edge the last bit of 4'h5 arrives -> par_out=4'h5, par_valid stays 1, overrun_err=0.
- Resync: start a frame with 1,1, then frame_start with bits 0,0,1,0 -> frame_err pulses once; result par_out=4'h4.
- Reset mid-frame: reset=1 after 2 bits, then a clean frame 0,1,1,1 -> all outputs 0 during reset; result par_out=4'hE.
